// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N-channel data selector with manual and scan modes.
//
// Manual mode presents the channel picked by sel one cycle later; scan mode
// walks through the channels on its own, spending max(dwell,1) cycles on each.
// The selector sits between a bank of parallel sources and a single consumer.
//
// Optional feature (macro MUX_SKIP_EN): adds skip_mask so that scan mode
// visits only unmasked channels. With the macro undefined every channel is
// visited and the port is absent.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   data_in    CHANNELS*WIDTH bits, channel k at [k*WIDTH +: WIDTH]
//   sel        manual channel select
//   en         block enable
//   mode       0 = manual, 1 = scan
//   dwell      cycles per channel in scan mode (0 behaves as 1)
//   skip_mask  (MUX_SKIP_EN only) bit k = 1 removes channel k from the scan
//   q          registered selected data
//   q_valid    q holds a fresh sample
//   cur_ch     channel currently presented on q
//   sel_err    manual select was out of range
//   scan_wrap  one-cycle pulse when the scan wraps back to the start
module mux_scan_reg #(
    parameter int unsigned       WIDTH       = 4,
    parameter int unsigned       CHANNELS    = 4,
    parameter int unsigned       SEL_W       = 4,
    parameter int unsigned       DWELL_W     = 8,
    parameter logic [WIDTH-1:0]  DEFAULT_VAL = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      en,
    input  logic                      mode,
    input  logic [DWELL_W-1:0]        dwell,
`ifdef MUX_SKIP_EN
    input  logic [CHANNELS-1:0]       skip_mask,
`endif
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid,
    output logic [SEL_W-1:0]          cur_ch,
    output logic                      sel_err,
    output logic                      scan_wrap
);

    localparam int unsigned NSEL = 2 ** SEL_W;
    localparam int unsigned SW1  = SEL_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [DWELL_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]     q_n;
    logic                 q_valid_n;
    logic [SEL_W-1:0]     cur_ch_n;
    logic                 sel_err_n;
    logic                 scan_wrap_n;

    logic [WIDTH-1:0]     chan [NSEL];
    logic                 sel_ok;
    logic [DWELL_W-1:0]   dwell_m1;
    logic [SEL_W-1:0]     adv_ch;
    logic                 adv_wrap;
    logic [SEL_W-1:0]     first_ch;
    logic                 any_ch;

    // Channel table padded to the full select range so any code indexes safely.
    for (genvar k = 0; k < NSEL; k++) begin : g_chan
        if (k < CHANNELS) begin : g_in
            assign chan[k] = data_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[k] = DEFAULT_VAL;
        end
    end

    assign sel_ok   = 32'(sel) < CHANNELS;
    assign dwell_m1 = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

`ifdef MUX_SKIP_EN
    logic [NSEL-1:0]  skip_ext;
    logic [SW1-1:0]   sum;
    logic [SEL_W-1:0] cand;
    logic             found;

    for (genvar k = 0; k < NSEL; k++) begin : g_skip
        if (k < CHANNELS) begin : g_in
            assign skip_ext[k] = skip_mask[k];
        end else begin : g_pad
            assign skip_ext[k] = 1'b1;
        end
    end

    // Next unmasked channel above cur_ch (wrapping) and lowest unmasked channel.
    always_comb begin : p_next_ch
        adv_ch   = cur_ch;
        adv_wrap = 1'b0;
        first_ch = '0;
        any_ch   = ~(&skip_ext);
        found    = 1'b0;
        sum      = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            sum  = {1'b0, cur_ch} + SW1'(i);
            cand = (sum >= SW1'(CHANNELS)) ? SEL_W'(sum - SW1'(CHANNELS)) : SEL_W'(sum);
            if (!found && !skip_ext[cand]) begin
                found    = 1'b1;
                adv_ch   = cand;
                adv_wrap = (sum >= SW1'(CHANNELS));
            end
        end
        for (int unsigned i = CHANNELS; i > 0; i--) begin
            if (!skip_ext[SEL_W'(i - 1)]) begin
                first_ch = SEL_W'(i - 1);
            end
        end
    end
`else
    // Plain ascending walk over every channel.
    always_comb begin : p_next_ch
        adv_wrap = (cur_ch >= SEL_W'(CHANNELS - 1));
        adv_ch   = adv_wrap ? '0 : cur_ch + SEL_W'(1);
        first_ch = '0;
        any_ch   = 1'b1;
    end
`endif

    // Next state and next register values; the target state decides the update.
    always_comb begin : p_next
        state_n     = IDLE;
        q_n         = q;
        q_valid_n   = 1'b0;
        cur_ch_n    = cur_ch;
        sel_err_n   = 1'b0;
        scan_wrap_n = 1'b0;
        cnt_n       = '0;

        if (en) begin
            state_n = mode ? SCAN : MANUAL;
        end

        case (state_n)
            MANUAL: begin
                cur_ch_n  = sel;
                q_n       = sel_ok ? chan[sel] : DEFAULT_VAL;
                sel_err_n = ~sel_ok;
                q_valid_n = 1'b1;
            end
            SCAN: begin
                if (state != SCAN) begin
                    cur_ch_n = first_ch;
                end else if (cnt >= dwell_m1) begin
                    // >= so a dwell shortened below the running count advances at once
                    cur_ch_n    = adv_ch;
                    scan_wrap_n = adv_wrap;
                end else begin
                    cnt_n = cnt + DWELL_W'(1);
                end
                // q follows the channel cur_ch will show, keeping the pair aligned
                if (any_ch) begin
                    q_n       = chan[cur_ch_n];
                    q_valid_n = 1'b1;
                end else begin
                    q_n         = DEFAULT_VAL;
                    scan_wrap_n = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            q         <= DEFAULT_VAL;
            q_valid   <= 1'b0;
            cur_ch    <= '0;
            sel_err   <= 1'b0;
            scan_wrap <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            q         <= q_n;
            q_valid   <= q_valid_n;
            cur_ch    <= cur_ch_n;
            sel_err   <= sel_err_n;
            scan_wrap <= scan_wrap_n;
        end
    end

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed self-checking bench for mux_scan_reg
// (WIDTH=4, CHANNELS=4, channels a,b,d,e). Covers reset, manual select,
// live data, idle hold, scan dwell, enable drop, mode switching, async reset
// mid-scan and, with MUX_SKIP_EN defined, the skip mask.
module tb_mux_scan_reg;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  sel;
    logic        en;
    logic        mode;
    logic [7:0]  dwell;
`ifdef MUX_SKIP_EN
    logic [3:0]  skip_mask;
`endif
    logic [3:0]  q;
    logic        q_valid;
    logic [3:0]  cur_ch;
    logic        sel_err;
    logic        scan_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_ch [4] = '{4'ha, 4'hb, 4'hd, 4'he};

    mux_scan_reg #(
        .WIDTH      (4),
        .CHANNELS   (4),
        .SEL_W      (4),
        .DWELL_W    (8),
        .DEFAULT_VAL(4'h0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .sel      (sel),
        .en       (en),
        .mode     (mode),
        .dwell    (dwell),
`ifdef MUX_SKIP_EN
        .skip_mask(skip_mask),
`endif
        .q        (q),
        .q_valid  (q_valid),
        .cur_ch   (cur_ch),
        .sel_err  (sel_err),
        .scan_wrap(scan_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (q !== 4'h0) begin n_fail++; $display("FAIL reset_q: got %h expected 0", q); end
        n_checks++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_q_valid: got %b expected 0", q_valid); end
        n_checks++; if (cur_ch !== 4'h0) begin n_fail++; $display("FAIL reset_cur_ch: got %h expected 0", cur_ch); end
        n_checks++; if (sel_err !== 1'b0 || scan_wrap !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got sel_err=%b scan_wrap=%b expected 0 0", sel_err, scan_wrap); end
        rst = 1'b0;
        tick();
        n_checks++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got q_valid=%b expected 0", q_valid); end
    endtask

    task automatic test_manual();
        en   = 1'b1;
        mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 4'(s);
            tick();
            n_checks++; if (q !== exp_ch[s]) begin n_fail++; $display("FAIL manual_q sel=%0d: got %h expected %h", s, q, exp_ch[s]); end
            n_checks++; if (cur_ch !== 4'(s) || sel_err !== 1'b0 || q_valid !== 1'b1) begin n_fail++; $display("FAIL manual_status sel=%0d: got cur_ch=%h sel_err=%b q_valid=%b expected %h 0 1", s, cur_ch, sel_err, q_valid, 4'(s)); end
        end
        for (int s = 4; s < 16; s++) begin
            sel = 4'(s);
            tick();
            n_checks++; if (q !== 4'h0 || sel_err !== 1'b1) begin n_fail++; $display("FAIL manual_range sel=%0d: got q=%h sel_err=%b expected 0 1", s, q, sel_err); end
            n_checks++; if (cur_ch !== 4'(s) || q_valid !== 1'b1) begin n_fail++; $display("FAIL manual_range_status sel=%0d: got cur_ch=%h q_valid=%b expected %h 1", s, cur_ch, q_valid, 4'(s)); end
        end
    endtask

    task automatic test_live_data();
        sel = 4'd2;
        tick();
        n_checks++; if (q !== 4'hd) begin n_fail++; $display("FAIL live_before: got %h expected d", q); end
        data_in[11:8] = 4'h7;
        tick();
        n_checks++; if (q !== 4'h7) begin n_fail++; $display("FAIL live_update: got %h expected 7", q); end
        data_in = 16'hedba;
        tick();
        n_checks++; if (q !== 4'hd) begin n_fail++; $display("FAIL live_restore: got %h expected d", q); end
    endtask

    task automatic test_idle_hold();
        sel = 4'd9;
        tick();
        n_checks++; if (q !== 4'h0 || sel_err !== 1'b1) begin n_fail++; $display("FAIL err_before_idle: got q=%h sel_err=%b expected 0 1", q, sel_err); end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (q !== 4'h0 || cur_ch !== 4'h9) begin n_fail++; $display("FAIL idle_hold cyc=%0d: got q=%h cur_ch=%h expected 0 9", i, q, cur_ch); end
            n_checks++; if (q_valid !== 1'b0 || sel_err !== 1'b0 || scan_wrap !== 1'b0) begin n_fail++; $display("FAIL idle_flags cyc=%0d: got q_valid=%b sel_err=%b scan_wrap=%b expected 0 0 0", i, q_valid, sel_err, scan_wrap); end
        end
    endtask

    task automatic test_scan_dwell();
        logic [1:0] ch;
        logic       wrap;
        dwell = 8'd3;
        mode  = 1'b1;
        en    = 1'b1;
        for (int t = 0; t < 15; t++) begin
            tick();
            ch   = 2'((t / 3) % 4);
            wrap = (t == 12);
            n_checks++; if (q !== exp_ch[ch] || cur_ch !== 4'(ch)) begin n_fail++; $display("FAIL scan3 t=%0d: got q=%h cur_ch=%h expected %h %h", t, q, cur_ch, exp_ch[ch], 4'(ch)); end
            n_checks++; if (scan_wrap !== wrap || q_valid !== 1'b1 || sel_err !== 1'b0) begin n_fail++; $display("FAIL scan3_flags t=%0d: got wrap=%b q_valid=%b sel_err=%b expected %b 1 0", t, scan_wrap, q_valid, sel_err, wrap); end
        end
        // counter sits at 2 here, above the new limit, so the next edge advances
        dwell = 8'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ch   = 2'((i + 1) % 4);
            wrap = (ch == 2'd0);
            n_checks++; if (q !== exp_ch[ch] || cur_ch !== 4'(ch)) begin n_fail++; $display("FAIL scan0 i=%0d: got q=%h cur_ch=%h expected %h %h", i, q, cur_ch, exp_ch[ch], 4'(ch)); end
            n_checks++; if (scan_wrap !== wrap) begin n_fail++; $display("FAIL scan0_wrap i=%0d: got %b expected %b", i, scan_wrap, wrap); end
        end
    endtask

    task automatic test_enable_drop();
        en = 1'b0;
        tick();
        dwell = 8'd2;
        en    = 1'b1;
        repeat (6) tick();
        n_checks++; if (q !== 4'hd || cur_ch !== 4'h2) begin n_fail++; $display("FAIL drop_setup: got q=%h cur_ch=%h expected d 2", q, cur_ch); end
        // advance is due on this edge; en low must suppress it
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (q !== 4'hd || cur_ch !== 4'h2) begin n_fail++; $display("FAIL drop_hold cyc=%0d: got q=%h cur_ch=%h expected d 2", i, q, cur_ch); end
            n_checks++; if (q_valid !== 1'b0 || scan_wrap !== 1'b0) begin n_fail++; $display("FAIL drop_flags cyc=%0d: got q_valid=%b scan_wrap=%b expected 0 0", i, q_valid, scan_wrap); end
        end
        en = 1'b1;
        tick();
        n_checks++; if (q !== 4'ha || cur_ch !== 4'h0 || q_valid !== 1'b1) begin n_fail++; $display("FAIL drop_restart: got q=%h cur_ch=%h q_valid=%b expected a 0 1", q, cur_ch, q_valid); end
    endtask

    task automatic test_mode_switch();
        repeat (2) tick();
        n_checks++; if (q !== 4'hb || cur_ch !== 4'h1) begin n_fail++; $display("FAIL switch_setup: got q=%h cur_ch=%h expected b 1", q, cur_ch); end
        mode = 1'b0;
        sel  = 4'd3;
        tick();
        n_checks++; if (q !== 4'he || cur_ch !== 4'h3 || scan_wrap !== 1'b0 || sel_err !== 1'b0) begin n_fail++; $display("FAIL switch_manual: got q=%h cur_ch=%h wrap=%b sel_err=%b expected e 3 0 0", q, cur_ch, scan_wrap, sel_err); end
        mode = 1'b1;
        tick();
        n_checks++; if (q !== 4'ha || cur_ch !== 4'h0 || q_valid !== 1'b1) begin n_fail++; $display("FAIL switch_scan: got q=%h cur_ch=%h q_valid=%b expected a 0 1", q, cur_ch, q_valid); end
    endtask

    task automatic test_reset_mid_scan();
        dwell = 8'd1;
        tick();
        n_checks++; if (q !== 4'hb || cur_ch !== 4'h1) begin n_fail++; $display("FAIL rst_setup: got q=%h cur_ch=%h expected b 1", q, cur_ch); end
        rst = 1'b1;
        #2;
        n_checks++; if (q !== 4'h0 || q_valid !== 1'b0 || cur_ch !== 4'h0) begin n_fail++; $display("FAIL rst_async: got q=%h q_valid=%b cur_ch=%h expected 0 0 0", q, q_valid, cur_ch); end
        en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (q !== 4'h0 || q_valid !== 1'b0 || scan_wrap !== 1'b0) begin n_fail++; $display("FAIL rst_release: got q=%h q_valid=%b wrap=%b expected 0 0 0", q, q_valid, scan_wrap); end
    endtask

`ifdef MUX_SKIP_EN
    task automatic test_skip();
        logic [3:0] exp_q [5] = '{4'hb, 4'he, 4'hb, 4'he, 4'hb};
        logic       exp_w [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        skip_mask = 4'b0101;
        dwell     = 8'd1;
        mode      = 1'b1;
        en        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (q !== exp_q[i] || scan_wrap !== exp_w[i]) begin n_fail++; $display("FAIL skip i=%0d: got q=%h wrap=%b expected %h %b", i, q, scan_wrap, exp_q[i], exp_w[i]); end
        end
        skip_mask = 4'b1111;
        tick();
        n_checks++; if (q !== 4'h0 || q_valid !== 1'b0) begin n_fail++; $display("FAIL skip_all: got q=%h q_valid=%b expected 0 0", q, q_valid); end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        data_in = 16'hedba;
        sel     = 4'd0;
        en      = 1'b0;
        mode    = 1'b0;
        dwell   = 8'd0;
`ifdef MUX_SKIP_EN
        skip_mask = 4'b0000;
`endif
        test_reset();
        test_manual();
        test_live_data();
        test_idle_hold();
        test_scan_dwell();
        test_enable_drop();
        test_mode_switch();
        test_reset_mid_scan();
`ifdef MUX_SKIP_EN
        test_skip();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
